// File: rtl/snake_game_sequencer.sv
`timescale 1ns/1ps
// snake_game_sequencer: IDLE/RUN/PAUSE/OVER game flow, frame-paced move
// stepping that speeds up with snake length, food hit detection and the
// length/score registers.
//
// Handshakes: every output pulse (move_tick, food_req) is a registered
// single-cycle strobe with no back-pressure; receivers must accept it in the
// cycle it is high. Button inputs are already-synchronised levels.
module snake_game_sequencer #(
  parameter int BASE_PERIOD = 8,
  parameter int MIN_PERIOD  = 2,
  parameter int INIT_LEN    = 3,
  parameter int MAX_LEN     = 99,
  parameter int FOOD_SIZE   = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic [9:0]  head_x,
  input  logic [9:0]  head_y,
  input  logic [9:0]  food_x,
  input  logic [9:0]  food_y,
  input  logic        collision,
  output logic        move_tick,
  output logic        snake_reset,
  output logic        food_req,
  output logic [9:0]  length,
  output logic [15:0] score,
  output logic [1:0]  game_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(BASE_PERIOD + 1);
  localparam int SPAN  = BASE_PERIOD - MIN_PERIOD;

  state_t           state;
  state_t           state_next;
  logic             start_prev;
  logic             pause_prev;
  logic             start_edge;
  logic             pause_edge;
  logic             eval_q;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] period;
  logic [10:0]      dx;
  logic [10:0]      dy;
  logic [10:0]      adx;
  logic [10:0]      ady;
  logic             hit;
  logic             evaluating;
  logic             eat;
  logic             go_run;
  logic             run_frame;
  logic             move_now;

  // State is the debug view of the FSM.
  assign game_state = state;

  // Step period shrinks by one frame per four body segments, floored at MIN_PERIOD.
  always_comb begin
    int step;
    step = int'(length >> 2);
    if (step > SPAN) step = SPAN;
    period = CNT_W'(BASE_PERIOD - step);
  end

  // Food hit window: 11-bit signed distance per axis, compared by magnitude.
  always_comb begin
    dx  = {1'b0, head_x} - {1'b0, food_x};
    dy  = {1'b0, head_y} - {1'b0, food_y};
    adx = dx[10] ? (11'd0 - dx) : dx;
    ady = dy[10] ? (11'd0 - dy) : dy;
    hit = (adx < 11'(FOOD_SIZE)) && (ady < 11'(FOOD_SIZE));
  end

  // Next-state logic; the evaluation cycle's collision outranks a pause edge.
  always_comb begin
    state_next = state;
    evaluating = eval_q && (state == S_RUN);
    case (state)
      S_IDLE:  if (start_edge) state_next = S_RUN;
      S_RUN: begin
        if (evaluating && collision) state_next = S_OVER;
        else if (pause_edge)         state_next = S_PAUSE;
      end
      S_PAUSE: if (pause_edge) state_next = S_RUN;
      S_OVER:  if (start_edge) state_next = S_IDLE;
      default: state_next = state;
    endcase
    go_run    = (state == S_IDLE) && start_edge;
    eat       = evaluating && !collision && hit;
    run_frame = (state == S_RUN) && (state_next == S_RUN) && frame_tick;
    move_now  = run_frame && (frame_cnt == period - CNT_W'(1));
  end

  // Button sampling and single-cycle rising-edge strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
      start_edge <= 1'b0;
      pause_edge <= 1'b0;
    end else begin
      start_prev <= start_btn;
      pause_prev <= pause_btn;
      start_edge <= start_btn & ~start_prev;
      pause_edge <= pause_btn & ~pause_prev;
    end
  end

  // FSM state register and registered control strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      snake_reset <= 1'b1;
      move_tick   <= 1'b0;
      eval_q      <= 1'b0;
      food_req    <= 1'b0;
    end else begin
      state       <= state_next;
      snake_reset <= (state == S_IDLE);
      move_tick   <= move_now;
      eval_q      <= move_tick;
      food_req    <= go_run | eat;
    end
  end

  // Frame counter, length and score.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      length    <= 10'(INIT_LEN);
      score     <= 16'd0;
    end else if (go_run) begin
      frame_cnt <= '0;
      length    <= 10'(INIT_LEN);
      score     <= 16'd0;
    end else begin
      if (run_frame) begin
        if (move_now) frame_cnt <= '0;
        else          frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (eat) begin
        if (length < 10'(MAX_LEN)) length <= length + 10'd1;
        if (score != 16'hFFFF)     score  <= score + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_snake_game_sequencer.sv
`timescale 1ns/1ps
// Directed bench for snake_game_sequencer: hit-window vector table plus
// hand-written sequences for start, pause, speed-up, saturation, collision
// and mid-game reset.
module tb_snake_game_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        start_btn;
  logic        pause_btn;
  logic [9:0]  head_x;
  logic [9:0]  head_y;
  logic [9:0]  food_x;
  logic [9:0]  food_y;
  logic        collision;
  logic        move_tick;
  logic        snake_reset;
  logic        food_req;
  logic [9:0]  length;
  logic [15:0] score;
  logic [1:0]  game_state;

  snake_game_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .head_x      (head_x),
    .head_y      (head_y),
    .food_x      (food_x),
    .food_y      (food_y),
    .collision   (collision),
    .move_tick   (move_tick),
    .snake_reset (snake_reset),
    .food_req    (food_req),
    .length      (length),
    .score       (score),
    .game_state  (game_state)
  );

  // Clock
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  int len_m;
  int score_m;

  typedef struct {
    int dx;
    int dy;
    bit hit;
  } hit_vec_t;

  hit_vec_t hv[8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One clock edge; inputs set before the call are sampled, outputs read 1ns after.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One frame pulse followed by an idle cycle; returns move_tick seen after the pulse.
  task automatic frame(output logic mt);
    frame_tick = 1'b1;
    cyc();
    mt = move_tick;
    frame_tick = 1'b0;
    cyc();
  endtask

  function automatic int exp_period(input int len);
    int s;
    s = len >> 2;
    if (s > 6) s = 6;
    return 8 - s;
  endfunction

  // Run frames until the expected move; checks it lands on frame p, then
  // clocks past the evaluation cycle so length/score/food_req are visible.
  task automatic run_period(input int p, input string name);
    logic mt;
    int   first;
    first = 0;
    for (int i = 1; i <= p; i++) begin
      frame(mt);
      if (mt && first == 0) first = i;
    end
    check(name, first, p);
    cyc();
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    cyc();
    cyc();
    start_btn = 1'b0;
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    cyc();
    cyc();
    pause_btn = 1'b0;
  endtask

  task automatic set_food(input int dx, input int dy);
    food_x = 10'(200 + dx);
    food_y = 10'(200 + dy);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic mt;
    int   moves;

    hv[0] = '{dx:  9, dy:  9, hit: 1'b1};
    hv[1] = '{dx: -9, dy: -9, hit: 1'b1};
    hv[2] = '{dx: 10, dy:  0, hit: 1'b0};
    hv[3] = '{dx:  0, dy: -10, hit: 1'b0};
    hv[4] = '{dx:  9, dy: -9, hit: 1'b1};
    hv[5] = '{dx: -10, dy: 5, hit: 1'b0};
    hv[6] = '{dx:  0, dy:  0, hit: 1'b1};
    hv[7] = '{dx: -9, dy: 10, hit: 1'b0};

    reset = 1'b1;
    frame_tick = 1'b0;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    collision = 1'b0;
    head_x = 10'd200;
    head_y = 10'd200;
    food_x = 10'd600;
    food_y = 10'd600;

    // Reset values
    cyc(); cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_state", game_state, 0);
    check("rst_snake_reset", snake_reset, 1);
    check("rst_move_tick", move_tick, 0);
    check("rst_food_req", food_req, 0);
    check("rst_length", length, 3);
    check("rst_score", score, 0);

    // Start game
    press_start();
    check("start_state", game_state, 1);
    check("start_food_req", food_req, 1);
    check("start_length", length, 3);
    check("start_score", score, 0);
    check("start_snake_reset_held", snake_reset, 1);
    cyc();
    check("start_snake_reset_release", snake_reset, 0);
    check("start_food_req_once", food_req, 0);
    len_m = 3;
    score_m = 0;

    // First move at frame 8
    run_period(8, "first_period");
    check("nohit_length", length, 3);

    // Pause with counter at 5
    for (int i = 0; i < 5; i++) begin
      frame(mt);
      check("pre_pause_no_move", mt, 0);
    end
    press_pause();
    check("pause_state", game_state, 2);
    moves = 0;
    for (int i = 0; i < 10; i++) begin
      frame(mt);
      if (mt) moves++;
    end
    check("paused_moves", moves, 0);
    press_pause();
    check("resume_state", game_state, 1);
    run_period(3, "resume_period");

    // Hit window table
    for (int v = 0; v < 8; v++) begin
      set_food(hv[v].dx, hv[v].dy);
      run_period(exp_period(len_m), "tbl_period");
      if (hv[v].hit) begin
        len_m++;
        score_m++;
      end
      check("tbl_length", length, len_m);
      check("tbl_score", score, score_m);
      check("tbl_food_req", food_req, int'(hv[v].hit));
      cyc();
      check("tbl_food_req_pulse", food_req, 0);
    end

    // Grow to 27: period reaches 2 at 24 and stays
    set_food(0, 0);
    while (len_m < 27) begin
      run_period(exp_period(len_m), "grow_period");
      len_m++;
      score_m++;
      check("grow_length", length, len_m);
    end
    run_period(2, "period_at_27");
    len_m++;
    score_m++;

    // Saturation: 100 hits in this game
    while (score_m < 100) begin
      run_period(exp_period(len_m), "sat_period");
      if (len_m < 99) len_m++;
      score_m++;
    end
    check("sat_length", length, 99);
    check("sat_score", score, 100);

    // Collision with food hit in the same evaluation
    collision = 1'b1;
    run_period(exp_period(len_m), "coll_period");
    check("coll_state", game_state, 3);
    check("coll_length", length, 99);
    check("coll_score", score, 100);
    check("coll_food_req", food_req, 0);
    collision = 1'b0;
    frame(mt);
    check("over_no_move", mt, 0);
    press_start();
    check("over_to_idle", game_state, 0);
    check("idle_snake_reset_lag", snake_reset, 0);
    cyc();
    check("idle_snake_reset", snake_reset, 1);

    // New game, then reset with a move_tick in flight
    press_start();
    check("restart_state", game_state, 1);
    check("restart_length", length, 3);
    check("restart_score", score, 0);
    check("restart_food_req", food_req, 1);
    set_food(400, 400);
    for (int i = 0; i < 7; i++) frame(mt);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check("pre_reset_move", move_tick, 1);
    reset = 1'b1;
    #1;
    check("midrst_state", game_state, 0);
    check("midrst_snake_reset", snake_reset, 1);
    check("midrst_move_tick", move_tick, 0);
    check("midrst_food_req", food_req, 0);
    check("midrst_length", length, 3);
    check("midrst_score", score, 0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("post_rst_move_tick", move_tick, 0);
    check("post_rst_food_req", food_req, 0);
    check("post_rst_state", game_state, 0);
    cyc();
    check("post_rst_move_tick2", move_tick, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
